// File: rtl/pa_fadd_round_single_pkg.sv
// Shared binary32 constants, rounding-mode encodings and fflags layout for the FADD round stage.
package pa_fadd_round_single_pkg;

    localparam int unsigned MANT_W   = 24;
    localparam int unsigned EXP_IN_W = 10;
    localparam int unsigned EXP_ADJ_W = 11;
    localparam int unsigned FP32_W   = 32;
    localparam int unsigned FLAGS_W  = 5;

    localparam int unsigned EXP_MAX = 255;

    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] FP32_MAXF = 32'h7F7F_FFFF;
    localparam logic [31:0] FP32_INF  = 32'h7F80_0000;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    localparam int unsigned FLAG_NX = 0;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_DZ = 3;
    localparam int unsigned FLAG_NV = 4;

    typedef struct packed {
        logic [FLAGS_W-1:0] fflags;
        logic [FP32_W-1:0]  data;
    } rnd_res_t;

endpackage

// File: rtl/pa_fadd_round_inc_single.sv
// Rounding increment decision shared by the single- and double-precision round stages.
module pa_fadd_round_inc_single
    import pa_fadd_round_single_pkg::*;
(
    input  logic [2:0] rm,
    input  logic       sign,
    input  logic       lsb,
    input  logic       g,
    input  logic       r,
    input  logic       s,
    output logic       inc_c
);

    logic nx;

    // Select the increment for the active mode; reserved modes truncate.
    always_comb begin
        nx    = g | r | s;
        inc_c = 1'b0;
        case (rm)
            RM_RNE:  inc_c = g & (r | s | lsb);
            RM_RTZ:  inc_c = 1'b0;
            RM_RDN:  inc_c = sign & nx;
            RM_RUP:  inc_c = ~sign & nx;
            RM_RMM:  inc_c = g;
            default: inc_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/pa_fadd_round_single.sv
// Binary32 round/pack stage with a single registered output slot and valid/stall/flush control.
module pa_fadd_round_single
    import pa_fadd_round_single_pkg::*;
(
    input  logic                cpuclk,
    input  logic                cpurst_b,
    input  logic                rnd_in_vld,
    output logic                rnd_in_rdy,
    input  logic                rnd_in_sign,
    input  logic [EXP_IN_W-1:0] rnd_in_exp,
    input  logic [MANT_W-1:0]   rnd_in_mant,
    input  logic                rnd_in_g,
    input  logic                rnd_in_r,
    input  logic                rnd_in_s,
    input  logic [2:0]          rnd_in_rm,
    input  logic                rnd_in_spec,
    input  logic [FP32_W-1:0]   rnd_in_spec_data,
    input  logic                rnd_in_spec_nv,
    input  logic                rnd_out_stall,
    input  logic                rnd_flush,
    output logic                rnd_out_vld,
    output logic [FP32_W-1:0]   rnd_out_data,
    output logic [FLAGS_W-1:0]  rnd_out_fflags
);

    logic                 inc_c;
    logic                 nx;
    logic                 is_zero;
    logic [MANT_W:0]      mant_rnd;
    logic [MANT_W-1:0]    mant_fin;
    logic [EXP_ADJ_W-1:0] exp_adj;
    logic                 ovf;
    logic [7:0]           exp_fld;
    logic [30:0]          ovf_mag;
    logic                 accept;
    rnd_res_t             res_c;

    pa_fadd_round_inc_single u_inc (
        .rm    (rnd_in_rm),
        .sign  (rnd_in_sign),
        .lsb   (rnd_in_mant[0]),
        .g     (rnd_in_g),
        .r     (rnd_in_r),
        .s     (rnd_in_s),
        .inc_c (inc_c)
    );

    assign rnd_in_rdy = ~rnd_out_vld | ~rnd_out_stall;
    assign accept     = rnd_in_vld & rnd_in_rdy;

    // Apply the increment, fold mantissa carry into the exponent, then pack with overflow/subnormal handling.
    always_comb begin
        res_c    = '0;
        nx       = rnd_in_g | rnd_in_r | rnd_in_s;
        is_zero  = (rnd_in_mant == '0) & ~nx;
        mant_rnd = {1'b0, rnd_in_mant} + (MANT_W+1)'(inc_c);
        mant_fin = mant_rnd[MANT_W-1:0];
        exp_adj  = EXP_ADJ_W'(rnd_in_exp);
        if (mant_rnd[MANT_W]) begin
            mant_fin = 24'h80_0000;
            exp_adj  = EXP_ADJ_W'(rnd_in_exp) + EXP_ADJ_W'(1);
        end
        ovf     = ~is_zero & (exp_adj >= EXP_ADJ_W'(EXP_MAX));
        exp_fld = mant_fin[MANT_W-1] ? exp_adj[7:0] : 8'd0;

        // Overflow saturates to Inf when rounding away from zero, otherwise to the largest finite value.
        ovf_mag = FP32_MAXF[30:0];
        case (rnd_in_rm)
            RM_RNE, RM_RMM: ovf_mag = FP32_INF[30:0];
            RM_RDN:         ovf_mag = rnd_in_sign ? FP32_INF[30:0] : FP32_MAXF[30:0];
            RM_RUP:         ovf_mag = rnd_in_sign ? FP32_MAXF[30:0] : FP32_INF[30:0];
            default:        ovf_mag = FP32_MAXF[30:0];
        endcase

        if (rnd_in_spec) begin
            res_c.data           = rnd_in_spec_data;
            res_c.fflags[FLAG_NV] = rnd_in_spec_nv;
        end else if (is_zero) begin
            res_c.data = {rnd_in_sign, 31'd0};
        end else if (ovf) begin
            res_c.data            = {rnd_in_sign, ovf_mag};
            res_c.fflags[FLAG_OF] = 1'b1;
            res_c.fflags[FLAG_NX] = 1'b1;
        end else begin
            res_c.data            = {rnd_in_sign, exp_fld, mant_fin[MANT_W-2:0]};
            res_c.fflags[FLAG_UF] = (exp_fld == 8'd0) & nx;
            res_c.fflags[FLAG_NX] = nx;
        end
    end

    // Output slot: flush kills, accept loads, stall holds, otherwise the slot drains.
    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rnd_out_vld    <= 1'b0;
            rnd_out_data   <= '0;
            rnd_out_fflags <= '0;
        end else if (rnd_flush) begin
            rnd_out_vld <= 1'b0;
        end else if (accept) begin
            rnd_out_vld    <= 1'b1;
            rnd_out_data   <= res_c.data;
            rnd_out_fflags <= res_c.fflags;
        end else if (!(rnd_out_stall && rnd_out_vld)) begin
            rnd_out_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pa_fadd_round_single.sv
// Scoreboard bench for the binary32 round/pack stage.
module tb_pa_fadd_round_single;

    logic        cpuclk;
    logic        cpurst_b;
    logic        rnd_in_vld;
    logic        rnd_in_rdy;
    logic        rnd_in_sign;
    logic [9:0]  rnd_in_exp;
    logic [23:0] rnd_in_mant;
    logic        rnd_in_g;
    logic        rnd_in_r;
    logic        rnd_in_s;
    logic [2:0]  rnd_in_rm;
    logic        rnd_in_spec;
    logic [31:0] rnd_in_spec_data;
    logic        rnd_in_spec_nv;
    logic        rnd_out_stall;
    logic        rnd_flush;
    logic        rnd_out_vld;
    logic [31:0] rnd_out_data;
    logic [4:0]  rnd_out_fflags;

    int          checks = 0;
    int          errors = 0;
    bit          tb_vld = 0;
    bit          use_dir = 0;
    logic [36:0] dir_exp;
    logic [36:0] exp_q[$];

    pa_fadd_round_single dut (
        .cpuclk           (cpuclk),
        .cpurst_b         (cpurst_b),
        .rnd_in_vld       (rnd_in_vld),
        .rnd_in_rdy       (rnd_in_rdy),
        .rnd_in_sign      (rnd_in_sign),
        .rnd_in_exp       (rnd_in_exp),
        .rnd_in_mant      (rnd_in_mant),
        .rnd_in_g         (rnd_in_g),
        .rnd_in_r         (rnd_in_r),
        .rnd_in_s         (rnd_in_s),
        .rnd_in_rm        (rnd_in_rm),
        .rnd_in_spec      (rnd_in_spec),
        .rnd_in_spec_data (rnd_in_spec_data),
        .rnd_in_spec_nv   (rnd_in_spec_nv),
        .rnd_out_stall    (rnd_out_stall),
        .rnd_flush        (rnd_flush),
        .rnd_out_vld      (rnd_out_vld),
        .rnd_out_data     (rnd_out_data),
        .rnd_out_fflags   (rnd_out_fflags)
    );

    initial cpuclk = 1'b0;
    always #5 cpuclk = ~cpuclk;

    // Reference rounding: treat g/r/s as a 3-bit fraction of one ulp and round the magnitude.
    function automatic logic [36:0] ref_round(input logic sgn, input int unsigned e_in,
                                              input int unsigned m_in, input logic g, input logic r,
                                              input logic s, input logic [2:0] rm, input logic spec,
                                              input logic [31:0] sd, input logic snv);
        int unsigned frac, q, e, mode;
        bit          nx, up, away, uf;
        logic [7:0]  fld;
        logic [31:0] data;
        if (spec) return {snv, 4'b0, sd};
        frac = (g ? 4 : 0) + (r ? 2 : 0) + (s ? 1 : 0);
        nx   = (frac != 0);
        if (m_in == 0 && !nx) return {5'b0, sgn, 31'd0};
        mode = (rm > 4) ? 1 : int'(rm);
        case (mode)
            0:       up = (frac > 4) || (frac == 4 && (m_in % 2) == 1);
            2:       up = sgn && nx;
            3:       up = !sgn && nx;
            4:       up = (frac >= 4);
            default: up = 0;
        endcase
        q = m_in + (up ? 1 : 0);
        e = e_in;
        if (q == (1 << 24)) begin
            q = q / 2;
            e = e + 1;
        end
        if (e >= 255) begin
            away = (mode == 0) || (mode == 4) || (mode == 2 && sgn) || (mode == 3 && !sgn);
            data = away ? {sgn, 31'h7F80_0000} : {sgn, 31'h7F7F_FFFF};
            return {5'b00101, data};
        end
        fld = (q >= (1 << 23)) ? 8'(e) : 8'd0;
        uf  = (fld == 8'd0) && nx;
        data = {sgn, fld, 23'(q % (1 << 23))};
        return {3'b000, uf, nx, data};
    endfunction

    task automatic check(input string name, input logic [36:0] got, input logic [36:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // One clock: advance the bench's own view of the output slot using the inputs held across the edge.
    task automatic tick();
        bit acc;
        @(posedge cpuclk);
        if (cpurst_b) begin
            acc = rnd_in_vld && (!tb_vld || !rnd_out_stall);
            if (rnd_flush) begin
                if (tb_vld && rnd_out_stall && exp_q.size() != 0) void'(exp_q.pop_back());
                tb_vld = 0;
            end else if (acc) begin
                exp_q.push_back(use_dir ? dir_exp :
                    ref_round(rnd_in_sign, int'(rnd_in_exp), int'(rnd_in_mant), rnd_in_g, rnd_in_r,
                              rnd_in_s, rnd_in_rm, rnd_in_spec, rnd_in_spec_data, rnd_in_spec_nv));
                tb_vld = 1;
            end else if (!(rnd_out_stall && tb_vld)) begin
                tb_vld = 0;
            end
        end
        #1;
    endtask

    task automatic set_op(input logic sgn, input logic [9:0] e, input logic [23:0] m,
                          input logic g, input logic r, input logic s, input logic [2:0] rm);
        rnd_in_sign = sgn; rnd_in_exp = e; rnd_in_mant = m;
        rnd_in_g = g; rnd_in_r = r; rnd_in_s = s; rnd_in_rm = rm;
        rnd_in_spec = 0; rnd_in_spec_data = '0; rnd_in_spec_nv = 0;
    endtask

    task automatic directed(input logic sgn, input logic [9:0] e, input logic [23:0] m,
                            input logic g, input logic r, input logic s, input logic [2:0] rm,
                            input logic [31:0] want_data, input logic [4:0] want_flags);
        set_op(sgn, e, m, g, r, s, rm);
        rnd_in_vld = 1; rnd_out_stall = 0; rnd_flush = 0;
        use_dir = 1; dir_exp = {want_flags, want_data};
        tick();
        use_dir = 0; rnd_in_vld = 0;
        tick();
    endtask

    // Monitor: slot state and ready each cycle; pop and compare whenever a result is handed downstream.
    always @(negedge cpuclk) begin
        if (cpurst_b) begin
            check("out_vld", 37'(rnd_out_vld), 37'(tb_vld));
            check("in_rdy", 37'(rnd_in_rdy), 37'(!tb_vld || !rnd_out_stall));
            if (rnd_out_vld && !rnd_out_stall) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result: got %h expected none", {rnd_out_fflags, rnd_out_data});
                end else begin
                    check("result", {rnd_out_fflags, rnd_out_data}, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        cpurst_b = 0;
        rnd_in_vld = 0; rnd_out_stall = 0; rnd_flush = 0;
        set_op(0, 10'd0, 24'd0, 0, 0, 0, 3'd0);
        #2;
        check("reset_state", {rnd_out_vld, rnd_out_fflags, rnd_out_data}, 38'd0);
        #10 cpurst_b = 1;
        tick();

        directed(0, 10'd127, 24'h800001, 1, 0, 0, 3'd0, 32'h3F80_0002, 5'b00001);
        directed(0, 10'd127, 24'h800000, 1, 0, 0, 3'd0, 32'h3F80_0000, 5'b00001);
        directed(0, 10'd127, 24'hFFFFFF, 1, 0, 0, 3'd3, 32'h4000_0000, 5'b00001);
        directed(0, 10'd254, 24'hFFFFFF, 1, 0, 0, 3'd0, 32'h7F80_0000, 5'b00101);
        directed(0, 10'd254, 24'hFFFFFF, 1, 0, 0, 3'd1, 32'h7F7F_FFFF, 5'b00001);
        directed(0, 10'd255, 24'h800000, 0, 1, 0, 3'd1, 32'h7F7F_FFFF, 5'b00101);
        directed(1, 10'd255, 24'h800000, 0, 0, 1, 3'd2, 32'hFF80_0000, 5'b00101);
        directed(1, 10'd255, 24'h800000, 0, 0, 1, 3'd3, 32'hFF7F_FFFF, 5'b00101);
        directed(0, 10'd255, 24'h800000, 0, 0, 1, 3'd2, 32'h7F7F_FFFF, 5'b00101);
        directed(0, 10'd1,   24'h7FFFFF, 1, 0, 0, 3'd0, 32'h0080_0000, 5'b00001);
        directed(1, 10'd1,   24'h000001, 1, 1, 0, 3'd2, 32'h8000_0002, 5'b00011);
        directed(0, 10'd1,   24'h000005, 0, 0, 0, 3'd0, 32'h0000_0005, 5'b00000);
        directed(1, 10'd40,  24'h000000, 0, 0, 0, 3'd3, 32'h8000_0000, 5'b00000);
        directed(0, 10'd127, 24'h800001, 1, 1, 1, 3'd6, 32'h3F80_0001, 5'b00001);
        directed(0, 10'd127, 24'h800000, 1, 0, 0, 3'd4, 32'h3F80_0001, 5'b00001);

        // Bypass result with NV
        set_op(0, 10'd127, 24'hFFFFFF, 1, 1, 1, 3'd3);
        rnd_in_spec = 1; rnd_in_spec_data = 32'h7FC0_0000; rnd_in_spec_nv = 1;
        rnd_in_vld = 1; use_dir = 1; dir_exp = {5'b10000, 32'h7FC0_0000};
        tick();
        use_dir = 0; rnd_in_vld = 0; rnd_in_spec = 0;
        tick();

        // Stall: A held for three cycles with B waiting, then B goes through
        set_op(0, 10'd130, 24'hA00000, 0, 0, 0, 3'd0);
        rnd_in_vld = 1;
        tick();
        rnd_out_stall = 1;
        set_op(1, 10'd100, 24'hC00003, 1, 0, 1, 3'd0);
        for (int i = 0; i < 3; i++) tick();
        rnd_out_stall = 0;
        tick();
        rnd_in_vld = 0;
        tick();

        // Flush with a valid input: nothing appears
        set_op(0, 10'd120, 24'h900000, 0, 0, 0, 3'd0);
        rnd_in_vld = 1; rnd_flush = 1;
        tick();
        rnd_in_vld = 0; rnd_flush = 0;
        tick();

        // Asynchronous reset in the middle of a stall
        set_op(0, 10'd128, 24'hB00000, 0, 1, 0, 3'd1);
        rnd_in_vld = 1;
        tick();
        rnd_in_vld = 0; rnd_out_stall = 1;
        tick();
        #2 cpurst_b = 0;
        #1;
        check("async_reset", {rnd_out_vld, rnd_out_fflags, rnd_out_data}, 38'd0);
        tb_vld = 0;
        exp_q.delete();
        tick();
        cpurst_b = 1; rnd_out_stall = 0;
        tick();

        // Randomised traffic with stalls and flushes
        for (int i = 0; i < 3000; i++) begin
            logic [9:0]  e;
            logic [23:0] m;
            e = ($urandom_range(0, 7) == 0) ? 10'd1 : 10'($urandom_range(1, 262));
            m = (e == 10'd1) ? 24'($urandom) : {1'b1, 23'($urandom)};
            set_op(1'($urandom), e, m, 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
            rnd_in_spec      = ($urandom_range(0, 7) == 0);
            rnd_in_spec_data = $urandom;
            rnd_in_spec_nv   = 1'($urandom);
            rnd_in_vld       = ($urandom_range(0, 3) != 0);
            rnd_out_stall    = ($urandom_range(0, 3) == 0);
            rnd_flush        = ($urandom_range(0, 15) == 0);
            tick();
        end
        rnd_in_vld = 0; rnd_out_stall = 0; rnd_flush = 0;
        tick();
        tick();
        check("queue_drained", 37'(exp_q.size()), 37'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pa_fadd_round_single.md
Name: pa_fadd_round_single

Overview:
- Rounding/packing stage of the single-precision FADD datapath, directly downstream of the normalization right-shifter.
- Consumes the shifted 24-bit mantissa plus guard/round/sticky bits, applies the RISC-V rounding mode, and handles mantissa carry-out, overflow and subnormal packing.
- Registers the IEEE-754 binary32 result and fflags in one pipeline stage with valid/stall/flush control.

Parameters:
- None. Widths are fixed for binary32. Width constants live in the shared package.

Ports:
- cpuclk  in  1  clock.
- cpurst_b  in  1  asynchronous active-low reset.
- rnd_in_vld  in  1  input operand valid.
- rnd_in_rdy  out  1  stage can accept; equals ~rnd_out_vld | ~rnd_out_stall.
- rnd_in_sign  in  1  result sign.
- rnd_in_exp  in  10  biased exponent, unsigned, for the hidden-bit position; subnormals arrive with exp=1 and mant[23]=0.
- rnd_in_mant  in  24  shifter data_out; bit 23 is the hidden bit.
- rnd_in_g  in  1  guard bit from shifter.
- rnd_in_r  in  1  round bit from shifter.
- rnd_in_s  in  1  sticky bit from shifter.
- rnd_in_rm  in  3  rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM.
- rnd_in_spec  in  1  special-result bypass (NaN/Inf/exact zero from the special path).
- rnd_in_spec_data  in  32  bypass result.
- rnd_in_spec_nv  in  1  invalid flag for the bypass.
- rnd_out_stall  in  1  downstream cannot take the result.
- rnd_flush  in  1  kill the in-flight op.
- rnd_out_vld  out  1  result valid.
- rnd_out_data  out  32  binary32 result.
- rnd_out_fflags  out  5  {NV,DZ,OF,UF,NX}.

Behaviour:
- Reset (cpurst_b low, asynchronous): rnd_out_vld=0, rnd_out_data=32'b0, rnd_out_fflags=5'b0. A reset mid-operation drops the op; there is no replay.
- Latency is 1 cycle. An op accepted at edge N (rnd_in_vld & rnd_in_rdy) is visible on the outputs after edge N.
- Register update at each edge, in priority order:
  - flush: out_vld←0; data and flags hold.
  - else accept: load the new op, out_vld←1.
  - else out_stall & out_vld: hold everything.
  - else: out_vld←0.
- A flush in the same cycle as an accept discards the new op (flush wins).
- Increment decision, with lsb=mant[0] and inexact NX=g|r|s:
  - RNE: g&(r|s|lsb).
  - RTZ: 0.
  - RDN: sign&NX.
  - RUP: ~sign&NX.
  - RMM: g.
  - rm 5–7: treated as RTZ, no flag.
- Mantissa: mant_rnd = {1'b0,mant}+inc, 25 bits. If bit 24 is set: mant_rnd←24'h800000 and exp←exp+1.
- Subnormal: if mant_rnd[23]=0, the exponent field is 0. A subnormal that rounds up into bit 23 naturally gives field 1.
- Overflow when exp≥255 after the carry adjustment: OF=1, NX=1. The result depends on mode:
  - RNE/RMM: ±Inf.
  - RTZ: ±7F7FFFFF.
  - RDN: +7F7FFFFF or −Inf.
  - RUP: +Inf or −FF7FFFFF.
- Underflow: UF = tiny-after-rounding & NX, where tiny means exponent field 0. An exact subnormal gives UF=0.
- Zero mantissa with g=r=s=0 packs as signed zero, no flags.
- Bypass (rnd_in_spec): out_data=spec_data, fflags={spec_nv,4'b0}. Rounding is ignored.
- DZ is always 0 in this stage.

Decomposition:
- Shared package holds:
  - FP32 constants: EXP_MAX=255, QNAN=7FC00000, MAXF=7F7FFFFF.
  - rm encodings RNE/RTZ/RDN/RUP/RMM.
  - fflags bit indices.
- One natural sub-module: pa_fadd_round_inc_single, a combinational increment decision over (rm, sign, lsb, g, r, s), also reused by the double-precision round stage.
- Pipeline register and packing stay in the top module.

Test Plan:
- RNE tie-to-even:
  - mant=800001, exp=127, g=1, r=s=0 → 3F800002, NX=1.
  - mant=800000, same g/r/s → 3F800000, NX=1.
- Carry-out: mant=FFFFFF, exp=127, g=1, RUP, sign=0 → 40000000, NX=1.
- Overflow:
  - exp=254, mant=FFFFFF, g=1, RNE → 7F800000, fflags=00101 (OF, NX).
  - Same with RTZ → 7F7FFFFF.
- Subnormal:
  - exp=1, mant=7FFFFF, g=1, RNE → 00800000, UF=0, NX=1.
  - mant=000001, g=1, r=1, RDN, sign=1 → 80000002, UF=1, NX=1.
- Handshake: accept op A, hold rnd_out_stall=1 for 3 cycles with op B presented.
  - rnd_in_rdy=0 and A holds throughout.
  - B is accepted the cycle stall drops and appears next cycle.
- Flush/reset:
  - Flush asserted with rnd_in_vld=1 → rnd_out_vld=0 next cycle.
  - cpurst_b pulsed low mid-stall → outputs clear immediately, without waiting for a clock edge.
